// File: rtl/bp_be_fe_queue_rollback_if.sv
// Handshake bundle between the FE queue producer, the BE scheduler and the
// rollback replay buffer that sits between them.
interface bp_be_fe_queue_rollback_if #(
  parameter int width_p = 96,
  parameter int els_p   = 8
);
  localparam int ptr_width_lp = $clog2(els_p) + 1;

  logic [width_p-1:0]      fe_queue_i;
  logic                    fe_queue_v_i;
  logic                    fe_queue_ready_o;
  logic [width_p-1:0]      fe_queue_o;
  logic                    fe_queue_v_o;
  logic                    fe_queue_yumi_i;
  logic                    fe_queue_deq_i;
  logic                    fe_queue_roll_i;
  logic                    fe_queue_clr_i;
  logic                    empty_o;
  logic [ptr_width_lp-1:0] count_o;

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
           fe_queue_roll_i, fe_queue_clr_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o, count_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
           fe_queue_roll_i, fe_queue_clr_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, empty_o, count_o
  );
endinterface

// File: rtl/bp_be_fe_queue_rollback.sv
// Replay buffer: entries are issued speculatively at rptr and retained until
// committed at cptr, so a miss can rewind rptr and a redirect can flush.
module bp_be_fe_queue_rollback #(
  parameter int width_p = 96,
  parameter int els_p   = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_be_fe_queue_rollback_if.slave q
);
  localparam int ptr_width_lp = $clog2(els_p) + 1;
  localparam int idx_width_lp = ptr_width_lp - 1;

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n, used;
  logic                    v, ready, enq, yumi_ok, deq_ok;

  // Wrap bit makes wptr - cptr an exact occupancy, including the full case.
  assign used    = wptr - cptr;
  assign ready   = (used != ptr_width_lp'(els_p));
  assign v       = (rptr != wptr);
  assign enq     = q.fe_queue_v_i & ready & ~q.fe_queue_clr_i;
  assign yumi_ok = q.fe_queue_yumi_i & v;
  assign deq_ok  = q.fe_queue_deq_i & (cptr != rptr);
  assign cptr_n  = cptr + ptr_width_lp'(deq_ok);

  always_comb begin
    wptr_n = wptr + ptr_width_lp'(enq);
    rptr_n = rptr;
    if (q.fe_queue_clr_i) begin
      wptr_n = cptr_n;
      rptr_n = cptr_n;
    end else if (q.fe_queue_roll_i) begin
      rptr_n = cptr_n;
    end else if (yumi_ok) begin
      rptr_n = rptr + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr[idx_width_lp-1:0]] <= q.fe_queue_i;
  end

  assign q.fe_queue_o       = mem[rptr[idx_width_lp-1:0]];
  assign q.fe_queue_v_o     = v;
  assign q.fe_queue_ready_o = ready;
  assign q.empty_o          = (wptr == cptr);
  assign q.count_o          = used;

  // Protocol misuse is ignored by the datapath above; these flag it in simulation.
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(q.fe_queue_yumi_i && !v))
    else $error("yumi asserted with no unread entry");

  a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(q.fe_queue_deq_i && (cptr == rptr)))
    else $error("deq asserted with no issued entry");
endmodule
